// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO responder: MMIO offsets,
// completion state encoding and store byte-lane selection.
package dmem_mmio_pkg;

  localparam logic [5:0] OFF_TOHOST     = 6'h00;
  localparam logic [5:0] OFF_CYCLE_LO   = 6'h04;
  localparam logic [5:0] OFF_CYCLE_HI   = 6'h08;
  localparam logic [5:0] OFF_INSTRET_LO = 6'h0C;
  localparam logic [5:0] OFF_INSTRET_HI = 6'h10;
  localparam logic [5:0] OFF_STATUS     = 6'h14;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_e;

  // Zero result means the store is illegal (bad width or misaligned).
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_SB:   byte_en = 4'b0001 << off;
      F3_SH:   byte_en = off[0] ? 4'b0000 : (4'b0011 << off);
      F3_SW:   byte_en = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM with per-byte write enables and asynchronous read;
// a read of the word being written returns the pre-write contents.
module dmem_ram #(
  parameter int RAM_WORDS = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [$clog2(RAM_WORDS)-1:0] addr_i,
  input  logic [31:0]                  wdata_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_mmio.sv
// Memory-stage load/store responder: RAM plus an MMIO window carrying the
// tohost completion register, cycle/instret counters and a timeout watchdog.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          MAX_CYCLES = 100000,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        RetireM,
  output logic [31:0] ReadDataM,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        access_err
);

  localparam int AW = $clog2(RAM_WORDS);

  state_e      state_q, state_d;
  logic [63:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0] cyc_snap_q, cyc_snap_d, ins_snap_q, ins_snap_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        err_q, err_d;

  logic [5:0]  off;
  logic        ram_hit, mmio_hit, running, mmio_sw_ok, tohost_wr, st_err, ld_err;
  logic [3:0]  be;
  logic [31:0] ram_rdata, mmio_rdata;

  assign off      = ALUResultM[5:0];
  assign ram_hit  = (ALUResultM[31:AW+2] == '0);
  assign mmio_hit = (ALUResultM[31:6] == MMIO_BASE[31:6]);
  assign be       = byte_en(Funct3M, ALUResultM[1:0]);
  assign running  = (state_q == RUN);

  // Word stores to TOHOST are live; word stores past STATUS are silently dropped.
  assign mmio_sw_ok = (Funct3M == F3_SW) && (off[1:0] == 2'b00) &&
                      ((off == OFF_TOHOST) || (off > OFF_STATUS));
  assign tohost_wr  = MemWriteM && running && mmio_hit && (Funct3M == F3_SW) &&
                      (off == OFF_TOHOST);
  assign st_err     = MemWriteM && (ram_hit ? (be == 4'b0000) : (mmio_hit ? !mmio_sw_ok : 1'b1));
  assign ld_err     = MemReadM && !ram_hit && !mmio_hit;

  dmem_ram #(
    .RAM_WORDS (RAM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we_i    (MemWriteM && running && ram_hit && (be != 4'b0000)),
    .be_i    (be),
    .addr_i  (ALUResultM[AW+1:2]),
    .wdata_i (WriteDataM << {ALUResultM[1:0], 3'b000}),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    mmio_rdata = 32'h0;
    case (off)
      OFF_CYCLE_LO:   mmio_rdata = cycle_q[31:0];
      OFF_CYCLE_HI:   mmio_rdata = cyc_snap_q;
      OFF_INSTRET_LO: mmio_rdata = instret_q[31:0];
      OFF_INSTRET_HI: mmio_rdata = ins_snap_q;
      OFF_STATUS:     mmio_rdata = {28'h0, err_q, state_q == PASS, !running, running};
      default:        mmio_rdata = 32'h0;
    endcase
  end

  assign ReadDataM = ram_hit ? ram_rdata : (mmio_hit ? mmio_rdata : 32'h0);

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    if (state_q == RUN) begin
      // A nonzero TOHOST write takes priority over a coincident timeout.
      if (tohost_wr && (WriteDataM != 32'h0)) begin
        if (WriteDataM == 32'h1) begin
          state_d = PASS;
        end else begin
          state_d     = FAIL;
          fail_code_d = WriteDataM[31:1];
        end
      end else if (cycle_q == 64'(MAX_CYCLES - 1)) begin
        state_d     = TIMEOUT;
        fail_code_d = '1;
      end
    end
  end

  always_comb begin
    cycle_d    = running ? cycle_q + 64'd1 : cycle_q;
    instret_d  = (running && RetireM) ? instret_q + 64'd1 : instret_q;
    cyc_snap_d = (MemReadM && mmio_hit && off == OFF_CYCLE_LO)   ? cycle_q[63:32]   : cyc_snap_q;
    ins_snap_d = (MemReadM && mmio_hit && off == OFF_INSTRET_LO) ? instret_q[63:32] : ins_snap_q;
    err_d      = err_q | st_err | ld_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fail_code_q <= '0;
      cycle_q     <= '0;
      instret_q   <= '0;
      cyc_snap_q  <= '0;
      ins_snap_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      cyc_snap_q  <= cyc_snap_d;
      ins_snap_q  <= ins_snap_d;
      err_q       <= err_d;
    end
  end

  assign done       = !running;
  assign pass       = (state_q == PASS);
  assign fail_code  = fail_code_q;
  assign access_err = err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: the driver queues expected values tagged with
// the cycle they apply to; a monitor on the falling edge pops and compares.
module tb_dmem_mmio;

  localparam logic [2:0]  SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [31:0] TOHOST  = 32'h8000_0000;
  localparam logic [31:0] CYC_LO  = 32'h8000_0004;
  localparam logic [31:0] CYC_HI  = 32'h8000_0008;
  localparam logic [31:0] INS_LO  = 32'h8000_000C;
  localparam logic [31:0] STATUS  = 32'h8000_0014;
  localparam int S_RD = 0, S_DONE = 1, S_PASS = 2, S_FC = 3, S_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWriteM = 1'b0, MemReadM = 1'b0, RetireM = 1'b0;
  logic [2:0]  Funct3M = SW;
  logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        done, pass, access_err;
  logic [30:0] fail_code;

  dmem_mmio #(.RAM_WORDS(1024), .MMIO_BASE(32'h8000_0000), .MAX_CYCLES(20), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemReadM(MemReadM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RetireM(RetireM),
    .ReadDataM(ReadDataM), .done(done), .pass(pass), .fail_code(fail_code),
    .access_err(access_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_RD:    pick = ReadDataM;
      S_DONE:  pick = {31'h0, done};
      S_PASS:  pick = {31'h0, pass};
      S_FC:    pick = {1'b0, fail_code};
      default: pick = {31'h0, access_err};
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e   = sb_q.pop_front();
      act = pick(e.sel);
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check missed its cycle (queued %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [31:0] v);
    chk_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic ret);
    @(posedge clk); #1;
    rst = 1'b0; MemWriteM = we; MemReadM = re; Funct3M = f3;
    ALUResultM = a; WriteDataM = wd; RetireM = ret;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SW, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; RetireM = 1'b0;
    Funct3M = SW; ALUResultM = 32'h0; WriteDataM = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // RAM stores, sub-word lanes, read-during-write
    do_reset();
    drive(1'b1, 1'b0, SW, 32'd100, 32'd25, 1'b0);
    expect_v("rst_done", S_DONE, 32'h0);
    expect_v("rst_pass", S_PASS, 32'h0);
    expect_v("rst_fail_code", S_FC, 32'h0);
    expect_v("rst_access_err", S_ERR, 32'h0);
    drive(1'b0, 1'b1, SW, 32'd100, 32'h0, 1'b0);
    expect_v("lw100_after_sw", S_RD, 32'd25);
    drive(1'b1, 1'b0, SB, 32'd101, 32'hAB, 1'b0);
    expect_v("read_during_write_old", S_RD, 32'd25);
    drive(1'b0, 1'b1, SW, 32'd100, 32'h0, 1'b0);
    expect_v("sb101", S_RD, 32'h0000_AB19);
    drive(1'b1, 1'b0, SH, 32'd102, 32'hBEEF, 1'b0);
    drive(1'b0, 1'b1, SW, 32'd100, 32'h0, 1'b0);
    expect_v("sh102", S_RD, 32'hBEEF_AB19);
    expect_v("legal_stores_no_err", S_ERR, 32'h0);

    // cycle / instret counters
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, SW, 32'h0, 32'h0, (i < 7));
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("cycle_lo", S_RD, 32'd10);
    drive(1'b0, 1'b1, SW, INS_LO, 32'h0, 1'b0);
    expect_v("instret_lo", S_RD, 32'd7);
    drive(1'b0, 1'b1, SW, CYC_HI, 32'h0, 1'b0);
    expect_v("cycle_hi_snap", S_RD, 32'h0);
    drive(1'b0, 1'b1, SW, STATUS, 32'h0, 1'b0);
    expect_v("status_run", S_RD, 32'h1);

    // PASS, then frozen stores and counters
    do_reset();
    drive(1'b1, 1'b0, SW, 32'h0, 32'h1234, 1'b0);
    drive(1'b1, 1'b0, SW, TOHOST, 32'h1, 1'b0);
    expect_v("pre_pass_done", S_DONE, 32'h0);
    drive(1'b1, 1'b0, SW, 32'h0, 32'd5, 1'b0);
    expect_v("pass_done", S_DONE, 32'h1);
    expect_v("pass_pass", S_PASS, 32'h1);
    expect_v("pass_fail_code", S_FC, 32'h0);
    drive(1'b0, 1'b1, SW, 32'h0, 32'h0, 1'b0);
    expect_v("store_after_pass_dropped", S_RD, 32'h1234);
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("cycle_frozen_a", S_RD, 32'd2);
    idle();
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("cycle_frozen_b", S_RD, 32'd2);

    // TOHOST 0 ignored, then FAIL
    do_reset();
    drive(1'b1, 1'b0, SW, TOHOST, 32'h0, 1'b0);
    idle();
    expect_v("tohost_zero_ignored", S_DONE, 32'h0);
    drive(1'b1, 1'b0, SW, TOHOST, 32'h7, 1'b0);
    drive(1'b0, 1'b1, SW, STATUS, 32'h0, 1'b0);
    expect_v("fail_done", S_DONE, 32'h1);
    expect_v("fail_pass", S_PASS, 32'h0);
    expect_v("fail_code_3", S_FC, 32'd3);
    expect_v("status_fail", S_RD, 32'h2);

    // access errors are sticky and suppress the write
    do_reset();
    drive(1'b1, 1'b0, SW, 32'd8, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 1'b0, SH, 32'hB, 32'hFFFF, 1'b0);
    expect_v("err_clear_before", S_ERR, 32'h0);
    drive(1'b1, 1'b0, SW, 32'h9000_0000, 32'h55, 1'b0);
    expect_v("err_misaligned_sh", S_ERR, 32'h1);
    drive(1'b0, 1'b1, SW, 32'h9000_0000, 32'h0, 1'b0);
    expect_v("unmapped_load_zero", S_RD, 32'h0);
    drive(1'b1, 1'b0, 3'b011, 32'd8, 32'h0, 1'b0);
    drive(1'b0, 1'b1, SW, 32'd8, 32'h0, 1'b0);
    expect_v("bad_stores_no_ram_change", S_RD, 32'hDEAD_BEEF);
    expect_v("err_sticky", S_ERR, 32'h1);
    drive(1'b0, 1'b1, SW, STATUS, 32'h0, 1'b0);
    expect_v("status_err_run", S_RD, 32'h9);
    do_reset();
    idle();
    expect_v("err_cleared_by_rst", S_ERR, 32'h0);
    expect_v("run_after_rst", S_DONE, 32'h0);
    drive(1'b0, 1'b1, SW, STATUS, 32'h0, 1'b0);
    expect_v("status_after_rst", S_RD, 32'h1);
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("cycle_restart", S_RD, 32'd2);

    // watchdog timeout after MAX_CYCLES RUN cycles
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (k == 20) expect_v("timeout_not_yet", S_DONE, 32'h0);
    end
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("timeout_done", S_DONE, 32'h1);
    expect_v("timeout_pass", S_PASS, 32'h0);
    expect_v("timeout_fail_code", S_FC, 32'h7FFF_FFFF);
    expect_v("timeout_cycle", S_RD, 32'd20);
    drive(1'b0, 1'b1, SW, CYC_LO, 32'h0, 1'b0);
    expect_v("timeout_cycle_frozen", S_RD, 32'd20);

    // TOHOST write on the timeout edge wins
    do_reset();
    for (int k = 1; k <= 19; k++) idle();
    drive(1'b1, 1'b0, SW, TOHOST, 32'h1, 1'b0);
    idle();
    expect_v("race_done", S_DONE, 32'h1);
    expect_v("race_pass", S_PASS, 32'h1);
    expect_v("race_fail_code", S_FC, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover_checks: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
